// File: rtl/risc_v_mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state codes, opcodes,
// ALU/immediate encodings and datapath mux selects.
package risc_v_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH     = 4'd0;
    localparam state_t S_DECODE    = 4'd1;
    localparam state_t S_MEMADR    = 4'd2;
    localparam state_t S_MEMREAD   = 4'd3;
    localparam state_t S_MEMWB     = 4'd4;
    localparam state_t S_MEMWRITE  = 4'd5;
    localparam state_t S_EXEC_R    = 4'd6;
    localparam state_t S_EXEC_I    = 4'd7;
    localparam state_t S_ALUWB     = 4'd8;
    localparam state_t S_BRANCH    = 4'd9;
    localparam state_t S_JAL       = 4'd10;
    localparam state_t S_JALR_LINK = 4'd11;
    localparam state_t S_JALR      = 4'd12;
    localparam state_t S_LUI       = 4'd13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_PC     = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'b00,
        CLS_R      = 2'b01,
        CLS_I      = 2'b10,
        CLS_BRANCH = 2'b11
    } op_class_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_LUI:    imm = IMM_U;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps instruction class and func3/func7 to an ALU operation and flags
// func3 values this controller does not implement.
module alu_decoder
    import risc_v_mc_pkg::*;
(
    input  logic [1:0] i_op_class,
    input  logic [2:0] i_func3,
    input  logic       i_func7,
    output logic [2:0] o_alu_control,
    output logic       o_legal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_legal       = 1'b1;
        case (i_op_class)
            CLS_R, CLS_I: begin
                case (i_func3)
                    // func7 selects sub only for register-register ops
                    3'b000:  o_alu_control = (i_op_class == CLS_R && i_func7) ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_control = ALU_AND;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b010:  o_alu_control = ALU_SLT;
                    default: o_legal = 1'b0;
                endcase
            end
            CLS_BRANCH: begin
                o_alu_control = ALU_SUB;
                o_legal = (i_func3 == 3'b000) || (i_func3 == 3'b001) ||
                          (i_func3 == 3'b100) || (i_func3 == 3'b101);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/risc_v_multicycle_controller.sv
// Moore-style multicycle RISC-V control FSM; strobes are forced low while rst is high
// so an instruction interrupted by reset cannot commit side effects.
module risc_v_multicycle_controller
    import risc_v_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       b31,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_state_next;
    op_class_t  w_op_class;
    logic       w_op_known;
    logic [2:0] w_dec_alu;
    logic       w_dec_legal;
    logic       w_bad_instr;
    logic       w_branch_taken;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    always_comb begin
        w_op_class = CLS_OTHER;
        w_op_known = 1'b1;
        case (op)
            OP_R:      w_op_class = CLS_R;
            OP_I:      w_op_class = CLS_I;
            OP_BRANCH: w_op_class = CLS_BRANCH;
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI: w_op_class = CLS_OTHER;
            default:   w_op_known = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_op_class    (w_op_class),
        .i_func3       (func3),
        .i_func7       (func7),
        .o_alu_control (w_dec_alu),
        .o_legal       (w_dec_legal)
    );

    assign w_bad_instr = !w_op_known || !w_dec_legal;

    always_comb begin
        case (func3)
            3'b000:  w_branch_taken = zero;
            3'b001:  w_branch_taken = !zero;
            3'b100:  w_branch_taken = b31;
            3'b101:  w_branch_taken = !b31;
            default: w_branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                if (!w_bad_instr) begin
                    case (op)
                        OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
                        OP_R:      w_state_next = S_EXEC_R;
                        OP_I:      w_state_next = S_EXEC_I;
                        OP_BRANCH: w_state_next = S_BRANCH;
                        OP_JAL:    w_state_next = S_JAL;
                        OP_JALR:   w_state_next = S_JALR_LINK;
                        OP_LUI:    w_state_next = S_LUI;
                        default:   w_state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:    w_state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   w_state_next = S_MEMWB;
            S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: w_state_next = S_ALUWB;
            S_JALR_LINK: w_state_next = S_JALR;
            default:     w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        adr_src     = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                // branch/jal target is precomputed into ALUOut here
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                w_illegal = w_bad_instr;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_MEM;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = w_dec_alu;
            end
            S_EXEC_I: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = w_dec_alu;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                w_pc_write  = w_branch_taken;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                w_pc_write = 1'b1;
            end
            S_JALR_LINK: begin
                result_src  = RES_PC;
                w_reg_write = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                w_pc_write = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign imm_src   = imm_src_of(op);
    assign pc_write  = w_pc_write  && !rst;
    assign ir_write  = w_ir_write  && !rst;
    assign mem_write = w_mem_write && !rst;
    assign reg_write = w_reg_write && !rst;
    assign illegal   = w_illegal   && !rst;

endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// Directed bench: each instruction is expanded into its expected per-cycle control
// vector by an instruction-level model and compared every cycle.
module tb_risc_v_multicycle_controller;

    typedef logic [17:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7;
    logic       zero;
    logic       b31;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_vec;
    logic exp_valid = 1'b0;
    logic exp_reset = 1'b0;
    vec_t dut_vec;

    always #5 clk = ~clk;

    risc_v_multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .b31(b31),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .illegal(illegal)
    );

    assign dut_vec = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                      alu_src_a, alu_src_b, alu_control, imm_src, illegal};

    task automatic chk(input string name, input vec_t act, input vec_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] o, input logic [2:0] f3);
        if (o == 7'b0110011 || o == 7'b0010011)
            return f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd4 || f3 == 3'd2;
        if (o == 7'b1100011)
            return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5;
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b1101111 ||
               o == 7'b1100111 || o == 7'b0110111;
    endfunction

    function automatic int ilen(input logic [6:0] o, input logic [2:0] f3);
        if (!is_legal(o, f3)) return 2;
        if (o == 7'b0000011) return 5;
        if (o == 7'b1100011) return 3;
        return 4;
    endfunction

    // expected control vector for cycle c of one instruction
    function automatic vec_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input logic s, input int c);
        logic pcw, adr, irw, mw, rw, ill;
        logic [1:0] rs, a, b;
        logic [2:0] alu, imm, aluop;
        pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        case (o)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b0110111: imm = 3'b011;
            7'b1101111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        case (f3)
            3'd0:    aluop = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'd7:    aluop = 3'b010;
            3'd6:    aluop = 3'b011;
            3'd4:    aluop = 3'b100;
            default: aluop = 3'b101;
        endcase
        if (c == 0) begin
            pcw = 1; irw = 1; b = 2'b10; rs = 2'b10;
        end else if (c == 1) begin
            a = 2'b01; b = 2'b01; ill = !is_legal(o, f3);
        end else if (o == 7'b0000011 || o == 7'b0100011) begin
            if (c == 2) begin a = 2'b10; b = 2'b01; end
            else if (c == 3) begin adr = 1; mw = (o == 7'b0100011); end
            else begin rs = 2'b01; rw = 1; end
        end else if (o == 7'b0110011 || o == 7'b0010011) begin
            if (c == 2) begin a = 2'b10; b = (o == 7'b0010011) ? 2'b01 : 2'b00; alu = aluop; end
            else rw = 1;
        end else if (o == 7'b1100011) begin
            a = 2'b10; alu = 3'b001;
            pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && s) || (f3 == 3'd5 && !s);
        end else if (o == 7'b1101111) begin
            if (c == 2) begin a = 2'b01; b = 2'b10; pcw = 1; end
            else rw = 1;
        end else if (o == 7'b1100111) begin
            if (c == 2) begin rs = 2'b11; rw = 1; end
            else begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
        end else begin
            if (c == 2) begin a = 2'b11; b = 2'b01; end
            else rw = 1;
        end
        return {pcw, adr, irw, mw, rw, rs, a, b, alu, imm, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            if (exp_reset)
                chk("reset_strobes", 18'({pc_write, ir_write, mem_write, reg_write, illegal}), 18'd0);
            else
                chk("cycle_outputs", dut_vec, exp_vec);
        end
    end

    // pin: selects hand-computed literal checks; rst_at: cycle at which reset is asserted (-1 none)
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic s, input int pin, input int rst_at);
        int n;
        int used;
        n = ilen(o, f3);
        used = n;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            op = o; func3 = f3; func7 = f7; zero = z; b31 = s;
            rst = (c == rst_at);
            exp_reset = (c == rst_at);
            exp_vec = model(o, f3, f7, z, s, c);
            exp_valid = 1'b1;
            #2;
            case (pin)
                1: chk("lw_reg_write", 18'({reg_write, result_src}), (c == 4) ? 18'b101 : 18'({1'b0, result_src}));
                2: if (c == 2) chk("sub_alu_control", 18'(alu_control), 18'b001);
                   else if (c == 3) chk("sub_aluwb_write", 18'(reg_write), 18'd1);
                3: if (c == 2) chk("bne_taken_pcw", 18'(pc_write), 18'd1);
                4: if (c == 2) chk("bne_not_taken_pcw", 18'(pc_write), 18'd0);
                5: if (c == 2) chk("jalr_link", 18'({reg_write, result_src}), 18'b111);
                   else if (c == 3) chk("jalr_jump", 18'({pc_write, result_src}), 18'b110);
                6: if (c == 1) chk("illegal_decode", 18'({illegal, pc_write, ir_write, mem_write, reg_write}), 18'b10000);
                7: if (c == 3) chk("sw_reset_mem_write", 18'(mem_write), 18'd0);
                default: ;
            endcase
            if (c == rst_at) begin
                used = c + 1;
                break;
            end
        end
        $display("instr op=%b f3=%b f7=%b zero=%b b31=%b cycles=%0d", o, f3, f7, z, s, used);
    endtask

    initial begin
        rst = 1'b1; op = 7'd0; func3 = 3'd0; func7 = 1'b0; zero = 1'b0; b31 = 1'b0;
        exp_vec = 18'd0;
        exp_reset = 1'b1;
        exp_valid = 1'b1;
        repeat (2) @(posedge clk);

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1, -1);  // lw
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, -1);  // sw
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1);  // add
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 2, -1);  // sub
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 0, -1);  // and
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 0, -1);  // or
        run_instr(7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 0, -1);  // xor
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 0, -1);  // slt
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0, -1);  // addi, func7 ignored
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 0, -1);  // slti
        run_instr(7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, 0, -1);  // xori
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, -1);  // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1);  // beq not taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3, -1);  // bne taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 4, -1);  // bne not taken
        run_instr(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, -1);  // blt taken
        run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 0, -1);  // bge not taken
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1);  // jal
        run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 5, -1);  // jalr
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1);  // lui
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 6, -1);  // unknown opcode
        run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 0, -1);  // R func3 001 unsupported
        run_instr(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, -1);  // branch func3 010 unsupported
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 7, 3);   // sw, reset in MEMWRITE
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1);   // reset while illegal in DECODE
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2);   // lw, reset in MEMADR
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1);  // add after reset

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_v_multicycle_controller.md
RISC_V_MULTICYCLE_CONTROLLER -- requirements
Module: risc_v_multicycle_controller

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; one clock; synchronous, active-high.
REQ-004 op  in  7  opcode of the latched instruction register.
REQ-005 func3  in  3  instruction bits [14:12].
REQ-006 func7  in  1  instruction bit 30.
REQ-007 zero  in  1  ALU result == 0.
REQ-008 b31  in  1  ALU result bit 31 (sign).
REQ-009 pc_write  out  1  PC load strobe.
REQ-010 adr_src  out  1  memory address: 0=PC, 1=ALUOut.
REQ-011 ir_write  out  1  latches instruction and oldPC.
REQ-012 mem_write  out  1  data memory write strobe.
REQ-013 reg_write  out  1  register file write strobe.
REQ-014 result_src  out  2  result mux: 00=ALUOut, 01=mem data, 10=ALU result, 11=PC.
REQ-015 alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1, 11=zero.
REQ-016 alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4.
REQ-017 alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-018 imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
REQ-019 illegal  out  1  unsupported instruction flag; high in DECODE only.

Function
REQ-020 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_LINK, JALR, LUI.
REQ-021 Unlisted outputs are 0 in every state; imm_src is decoded from op in every state.
REQ-022 FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1; next DECODE.
REQ-023 DECODE: a=01, b=01, add (branch/jal target into ALUOut). Next state by op: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, 1100111->JALR_LINK, 0110111->LUI. Any other op, or unsupported func3/func7 combination: illegal=1, next FETCH, no write strobes.
REQ-024 MEMADR: a=10, b=01, add; next MEMREAD for lw, MEMWRITE for sw.
REQ-025 MEMREAD: adr_src=1, result_src=00; next MEMWB. MEMWB: result_src=01, reg_write=1; next FETCH.
REQ-026 MEMWRITE: adr_src=1, result_src=00, mem_write=1; next FETCH.
REQ-027 EXEC_R: a=10, b=00; EXEC_I: a=10, b=01; both next ALUWB. ALUWB: result_src=00, reg_write=1; next FETCH.
REQ-028 ALU decode: func3 000->add (R with func7=1: sub; I ignores func7), 111 and, 110 or, 100 xor, 010 slt; other func3 illegal.
REQ-029 BRANCH: a=10, b=00, sub, result_src=00; pc_write=1 iff (func3 000 & zero)|(001 & ~zero)|(100 & b31)|(101 & ~b31); other func3 illegal in DECODE; next FETCH.
REQ-030 JAL: a=01, b=10, add, result_src=00, pc_write=1; next ALUWB (writes oldPC+4).
REQ-031 JALR_LINK: result_src=11, reg_write=1; next JALR. JALR: a=10, b=01, add, result_src=10, pc_write=1; next FETCH.
REQ-032 LUI: a=11, b=01, add; next ALUWB.
REQ-033 Cycles per instruction: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 4, lui 4, illegal 2.
REQ-034 At most one of mem_write/reg_write high in any cycle; ir_write only in FETCH.

Reset
REQ-035 rst=1 at a rising edge: state<=FETCH, overriding any transition, including mid-instruction.
REQ-036 While rst=1 all strobes (pc_write, ir_write, mem_write, reg_write) and illegal SHALL be 0; other outputs are don't-care.
REQ-037 First cycle after rst falls is FETCH.

Structure
REQ-038 Shared package risc_v_mc_pkg holds the state enum, opcode constants, alu_control codes, imm_src codes and mux select codes.
REQ-039 One sub-module alu_decoder (op class, func3, func7 -> alu_control, legal); FSM and output decode stay in the top.

Verification
REQ-040 lw (op 0000011): FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5 with result_src=01.
REQ-041 R sub (func3 000, func7 1): alu_control=001 in EXEC_R; reg_write in ALUWB; 4 cycles.
REQ-042 bne, zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-043 jalr: reg_write with result_src=11 in cycle 3; pc_write with result_src=10 in cycle 4.
REQ-044 op 1111111 -> illegal=1 in DECODE, no strobes, FETCH next cycle.
REQ-045 rst=1 during MEMWRITE -> mem_write=0 that cycle; FETCH next cycle.
